// File: rtl/uart_cmd_bridge_pkg.sv
// Shared command/response codes, FSM state encoding and byte-lane helper for
// the UART command bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS,
    ST_SEND
  } state_e;

  // Little-endian byte lane select: lane 0 is bits [7:0].
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_cmd_bridge_if.sv
// Bundles the RX FIFO, TX FIFO and register-bus signals seen by the bridge.
// master = bridge side, slave = UART/bus environment side.
interface uart_cmd_bridge_if;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        rx_fifo_flush_enable;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    input  rx_empty, r_data, tx_full, bus_rdata, bus_ack,
    output rd_uart, rx_fifo_flush_enable, wr_uart, w_data,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output rx_empty, r_data, tx_full, bus_rdata, bus_ack,
    input  rd_uart, rx_fifo_flush_enable, wr_uart, w_data,
           bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/uart_cmd_bridge_timeout.sv
// Inactivity counter: cleared on request, counts while enabled and saturates
// at TIMEOUT, flagging hit_o while it sits there.
module bridge_timeout #(
  parameter int TIMEOUT = 50000,
  parameter int TO_W    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_bridge.sv
// Byte-protocol command bridge: pops write/read frames from the UART RX FIFO,
// runs one register access on the req/ack bus and pushes the reply to TX.
module uart_cmd_bridge #(
  parameter int TIMEOUT = 50000,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  uart_cmd_bridge_if.master  bif
);
  import uart_bridge_pkg::*;

  state_e      state_q, state_d;
  logic        active_q;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [31:0] rsp_q, rsp_d;
  logic [1:0]  rsp_last_q, rsp_last_d;
  logic [1:0]  rsp_idx_q, rsp_idx_d;

  logic rd_pop;
  logic flush;
  logic to_clr;
  logic to_en;
  logic to_hit;

  bridge_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (to_clr),
    .en_i  (to_en),
    .hit_o (to_hit)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dcnt_d     = dcnt_q;
    rsp_d      = rsp_q;
    rsp_last_d = rsp_last_q;
    rsp_idx_d  = rsp_idx_q;
    rd_pop     = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      // active_q keeps the pop strobe quiet while reset is held
      ST_IDLE: begin
        if (active_q && !bif.rx_empty) begin
          rd_pop = 1'b1;
          if (bif.r_data == CMD_WR) begin
            we_d    = 1'b1;
            state_d = ST_GET_ADDR;
          end else if (bif.r_data == CMD_RD) begin
            we_d    = 1'b0;
            state_d = ST_GET_ADDR;
          end else begin
            rsp_d      = {24'h0, RSP_BAD};
            rsp_last_d = 2'd0;
            rsp_idx_d  = 2'd0;
            state_d    = ST_SEND;
          end
        end
      end

      ST_GET_ADDR: begin
        if (to_hit) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (!bif.rx_empty) begin
          rd_pop = 1'b1;
          addr_d = bif.r_data;
          if (we_q) begin
            dcnt_d  = 2'd0;
            state_d = ST_GET_DATA;
          end else begin
            state_d = ST_BUS;
          end
        end
      end

      ST_GET_DATA: begin
        if (to_hit) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (!bif.rx_empty) begin
          rd_pop                       = 1'b1;
          wdata_d[{dcnt_q, 3'b000} +: 8] = bif.r_data;
          dcnt_d                       = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            state_d = ST_BUS;
          end
        end
      end

      // ack takes priority over a timeout landing in the same cycle
      ST_BUS: begin
        if (bif.bus_ack) begin
          if (we_q) begin
            rsp_d      = {24'h0, RSP_OK};
            rsp_last_d = 2'd0;
          end else begin
            rsp_d      = bif.bus_rdata;
            rsp_last_d = 2'd3;
          end
          rsp_idx_d = 2'd0;
          state_d   = ST_SEND;
        end else if (to_hit) begin
          rsp_d      = {24'h0, RSP_ERR};
          rsp_last_d = 2'd0;
          rsp_idx_d  = 2'd0;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!bif.tx_full) begin
          if (rsp_idx_q == rsp_last_q) begin
            rsp_idx_d = 2'd0;
            state_d   = ST_IDLE;
          end else begin
            rsp_idx_d = rsp_idx_q + 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign to_clr = (state_d != state_q) || rd_pop;
  assign to_en  = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA) || (state_q == ST_BUS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      active_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 32'h0;
      dcnt_q     <= 2'd0;
      rsp_q      <= 32'h0;
      rsp_last_q <= 2'd0;
      rsp_idx_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      active_q   <= 1'b1;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dcnt_q     <= dcnt_d;
      rsp_q      <= rsp_d;
      rsp_last_q <= rsp_last_d;
      rsp_idx_q  <= rsp_idx_d;
    end
  end

  assign bif.rd_uart              = rd_pop;
  assign bif.rx_fifo_flush_enable = flush;
  assign bif.wr_uart              = (state_q == ST_SEND) && !bif.tx_full;
  assign bif.w_data               = (state_q == ST_SEND) ? byte_sel(rsp_q, rsp_idx_q) : 8'h00;
  assign bif.bus_req              = (state_q == ST_BUS);
  assign bif.bus_we               = we_q;
  assign bif.bus_addr             = addr_q;
  assign bif.bus_wdata            = wdata_q;

endmodule
